bcd_disp_scan: RTL and testbench
================================

# bcd_disp_scan

Four-digit multiplexed 7-segment display driver that consumes the 16-bit packed BCD sum produced by the BCD adder stage and drives the board's common-anode display. It latches a BCD word on a load strobe, then time-multiplexes the four digits with a programmable refresh prescaler. Each digit is decoded to active-low segments, and any nibble above 9 is flagged.

## Interface
Parameters:
- DIV_W, default 17: prescaler width. The digit slot advances once every 2^DIV_W clocks.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld  in  1  load strobe. Captures bcd_in and dp_in on the same rising edge.
- bcd_in  in  16  packed BCD word. [3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal-point enables, one per digit, active-high.
- blank  in  1  forces the whole display dark while high.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
- an  out  4  active-low digit enables, one-hot-low, registered.
- err  out  1  high while the latched word contains a nibble greater than 9, registered.

## Operation
- Registers:
  - val[15:0] and dpr[3:0]: loaded when ld=1.
  - pre[DIV_W-1:0]: free-running prescaler; increments every clock and wraps to 0.
  - idx[1:0]: digit slot; increments mod 4 on any clock where pre is all-ones.
- Scan state machine: four states S0→S1→S2→S3→S0. Each state is held for 2^DIV_W clocks. State Sn selects nibble val[4n+3:4n] and drives an = ~(1<<n).
- Decode, for gfedcba active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
  - Nibbles 10–15 show 'E' = 86.
  - seg[7] = ~dpr[idx].
- err = OR over all four nibbles of (nibble > 9). It is evaluated on val, not on the current slot.
- blank=1: an=4'hF, seg=8'hFF. pre and idx keep running. ld is still honoured.
- Reset values:
  - val=0, dpr=0, pre=0, idx=0.
  - seg=8'hFF, an=4'hF, err=0.
- Reset mid-scan: asserting rst_n low clears all state immediately, asynchronously. The display goes dark within the same cycle.

## Timing
- ld at edge k: val is updated at edge k. seg, an and err reflect the new val from edge k+1 onward.
- Outputs at edge k are computed from val, dpr, idx and blank as they stood before edge k. This gives a fixed one-cycle output lag.
- First edge after reset release: an=4'hE, seg=8'hC0 (digit 0 showing 0).
- ld and an idx advance on the same edge: both take effect. The newly selected slot shows the new val at the following edge.
- Consecutive ld pulses: the last one wins. There is no handshake; ld may be held high continuously.
- pre wrap: all-ones→0 and idx 3→0 occur on the same edge.

## Configuration
- BCD_DISP_LZB_EN, when defined, enables leading-zero blanking:
  - Digit n (n = 3, 2, 1) is dark (an bit high, seg=8'hFF) when nibbles n..3 are all 0 and dpr[n]=0.
  - Digit 0 is never blanked.
- When BCD_DISP_LZB_EN is undefined, all four digits are always shown, including leading zeros.
- err is unaffected by the macro.

## Structure
- Shared package bcd_disp_pkg holds:
  - NDIG=4
  - the ten digit segment constants
  - SEG_ERR=8'h86
  - SEG_OFF=8'hFF
  - AN_OFF=4'hF
- Sub-module bcd_seg_dec: purely combinational, nibble+dp → 8-bit active-low pattern, including the 'E' fallback. It is instantiated once, on the idx-muxed nibble.
- The top holds the val/dpr registers, prescaler, idx state machine, blanking logic and output registers.

## Test plan
Use DIV_W=2 in simulation.
- Reset: hold rst_n low, then release → seg=FF, an=F, err=0 while low. The first edge after release gives an=E, seg=C0.
- Load 16'h1234 with dp_in=4'b0100, observe 16 clocks → an cycles E,D,B,7 every 4 clocks. seg follows 99, B0, 24 (dp on digit 2), F9.
- Load 16'h0A05 → digit 2 shows 86 and err=1 from the edge after ld. Reloading 16'h0905 clears err on the next edge.
- Hold blank=1 for 8 clocks mid-scan → an=F, seg=FF throughout. On release the scan resumes at the slot reached by the free-running idx.
- Load 16'h0007 with the macro defined → only an=E is ever low, seg=F8. Without the macro: digits 3..1 show C0.
- Assert rst_n low mid-slot, asynchronously → an=F and seg=FF before the next clock edge, and val clears.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the four-digit BCD display driver.
// Holds the digit count, active-low 7-segment patterns ({dp,g,f,e,d,c,b,a}, dp off),
// the 'E' error glyph, the dark values for segments/anodes and the scan state type.
package bcd_disp_pkg;

  localparam int unsigned NDIG = 4;

  // Digit glyphs, active-low, dp bit off.
  localparam logic [7:0] SEG_D0 = 8'hC0;
  localparam logic [7:0] SEG_D1 = 8'hF9;
  localparam logic [7:0] SEG_D2 = 8'hA4;
  localparam logic [7:0] SEG_D3 = 8'hB0;
  localparam logic [7:0] SEG_D4 = 8'h99;
  localparam logic [7:0] SEG_D5 = 8'h92;
  localparam logic [7:0] SEG_D6 = 8'h82;
  localparam logic [7:0] SEG_D7 = 8'hF8;
  localparam logic [7:0] SEG_D8 = 8'h80;
  localparam logic [7:0] SEG_D9 = 8'h90;

  localparam logic [7:0] SEG_ERR = 8'h86;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Scan slot; the encoding doubles as the digit index.
  typedef enum logic [1:0] {
    StS0 = 2'd0,
    StS1 = 2'd1,
    StS2 = 2'd2,
    StS3 = 2'd3
  } scan_state_e;

  // True when a nibble is not a valid BCD digit.
  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Ports:
//   nib  in  4  BCD digit; 10..15 render as 'E'
//   dp   in  1  decimal point enable, active-high
//   seg  out 8  active-low {dp,g,f,e,d,c,b,a}
module bcd_seg_dec
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_ERR;
    case (nib)
      4'd0:    glyph = SEG_D0;
      4'd1:    glyph = SEG_D1;
      4'd2:    glyph = SEG_D2;
      4'd3:    glyph = SEG_D3;
      4'd4:    glyph = SEG_D4;
      4'd5:    glyph = SEG_D5;
      4'd6:    glyph = SEG_D6;
      4'd7:    glyph = SEG_D7;
      4'd8:    glyph = SEG_D8;
      4'd9:    glyph = SEG_D9;
      default: glyph = SEG_ERR;
    endcase
  end

  assign seg = {~dp, glyph[6:0]};

endmodule

// File: rtl/bcd_disp_scan.sv
// Four-digit multiplexed common-anode 7-segment driver.
// Latches a packed BCD word and decimal points on ld, then scans digits 0..3, each held for
// 2^DIV_W clocks. All outputs are registered and lag the internal state by one clock.
// Optional leading-zero blanking is enabled by defining BCD_DISP_LZB_EN.
// Ports:
//   clk     in  1   system clock
//   rst_n   in  1   asynchronous active-low reset
//   ld      in  1   load strobe for bcd_in/dp_in
//   bcd_in  in  16  packed BCD, [3:0] is the rightmost digit
//   dp_in   in  4   decimal-point enables, active-high
//   blank   in  1   forces the display dark
//   seg     out 8   active-low {dp,g,f,e,d,c,b,a}
//   an      out 4   active-low digit enables
//   err     out 1   latched word holds a nibble above 9
module bcd_disp_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  logic [15:0]      val_q;
  logic [3:0]       dpr_q;
  logic [DIV_W-1:0] pre_q;
  scan_state_e      state_q;
  logic [7:0]       seg_q;
  logic [3:0]       an_q;
  logic             err_q;

  logic [1:0] idx;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic [7:0] dec_seg;
  logic       dark;
  logic [7:0] seg_d;
  logic [3:0] an_d;
  logic       err_d;

  assign idx = state_q;

  // Select the current slot's nibble and decimal point.
  always_comb begin
    cur_nib = val_q[3:0];
    cur_dp  = dpr_q[0];
    an_d    = 4'b1110;
    unique case (state_q)
      StS0: begin cur_nib = val_q[3:0];   cur_dp = dpr_q[0]; an_d = 4'b1110; end
      StS1: begin cur_nib = val_q[7:4];   cur_dp = dpr_q[1]; an_d = 4'b1101; end
      StS2: begin cur_nib = val_q[11:8];  cur_dp = dpr_q[2]; an_d = 4'b1011; end
      StS3: begin cur_nib = val_q[15:12]; cur_dp = dpr_q[3]; an_d = 4'b0111; end
      default: begin cur_nib = val_q[3:0]; cur_dp = dpr_q[0]; an_d = 4'b1110; end
    endcase
  end

  bcd_seg_dec u_dec (
    .nib (cur_nib),
    .dp  (cur_dp),
    .seg (dec_seg)
  );

`ifdef BCD_DISP_LZB_EN
  // A digit is a leading zero when it and every digit to its left are zero and it carries
  // no decimal point. Digit 0 always shows.
  logic [3:1] lead_zero;

  always_comb begin
    lead_zero[3] = (val_q[15:12] == 4'd0) && !dpr_q[3];
    lead_zero[2] = (val_q[15:8] == 8'd0) && !dpr_q[2];
    lead_zero[1] = (val_q[15:4] == 12'd0) && !dpr_q[1];
    dark = 1'b0;
    unique case (state_q)
      StS1:    dark = lead_zero[1];
      StS2:    dark = lead_zero[2];
      StS3:    dark = lead_zero[3];
      default: dark = 1'b0;
    endcase
  end
`else
  assign dark = 1'b0;
`endif

  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      err_d = err_d | nib_bad(val_q[4*i +: 4]);
    end
  end

  assign seg_d = (blank || dark) ? SEG_OFF : dec_seg;

  // Data registers, prescaler, scan FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= 16'h0000;
      dpr_q   <= 4'h0;
      pre_q   <= '0;
      state_q <= StS0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      err_q   <= 1'b0;
    end else begin
      if (ld) begin
        val_q <= bcd_in;
        dpr_q <= dp_in;
      end
      pre_q <= pre_q + DIV_W'(1);
      if (&pre_q) begin
        unique case (state_q)
          StS0:    state_q <= StS1;
          StS1:    state_q <= StS2;
          StS2:    state_q <= StS3;
          StS3:    state_q <= StS0;
          default: state_q <= StS0;
        endcase
      end
      seg_q <= seg_d;
      an_q  <= (blank || dark) ? AN_OFF : an_d;
      err_q <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

  // idx is kept for readability of the scan slot in waveforms.
  logic unused_idx;
  assign unused_idx = ^idx;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Self-checking bench for bcd_disp_scan with DIV_W=2 (one slot per 4 clocks).
// A spec-level model tracks the latched word, prescaler count and digit slot as integers
// and predicts each registered output from the state seen before every edge.
module tb_bcd_disp_scan;

  logic        clk;
  logic        rst_n;
  logic        ld;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_disp_scan #(.DIV_W(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (ld),
    .bcd_in (bcd_in),
    .dp_in  (dp_in),
    .blank  (blank),
    .seg    (seg),
    .an     (an),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int          m_val;
  int          m_dpr;
  int          m_pre;
  int          m_idx;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_err;

  logic [7:0] glyphs [16];

  function automatic int nibble(int v, int n);
    return (v >> (4 * n)) & 15;
  endfunction

  task automatic model_reset();
    m_val = 0;
    m_dpr = 0;
    m_pre = 0;
    m_idx = 0;
  endtask

  // Predict outputs from pre-edge state, advance one clock, update the model.
  task automatic tick();
    bit dark;
    bit dp_on;
    int nib;
    bit take;
    int nv;
    int nd;
    nib   = nibble(m_val, m_idx);
    dp_on = ((m_dpr >> m_idx) & 1) == 1;
    dark  = blank;
`ifdef BCD_DISP_LZB_EN
    if (m_idx > 0 && (m_val >> (4 * m_idx)) == 0 && !dp_on) dark = 1;
`endif
    if (dark) begin
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      exp_seg    = glyphs[nib];
      exp_seg[7] = !dp_on;
      exp_an     = 4'hF ^ (4'(1) << m_idx);
    end
    exp_err = 0;
    for (int i = 0; i < 4; i++) if (nibble(m_val, i) > 9) exp_err = 1;
    take = ld;
    nv   = int'(bcd_in);
    nd   = int'(dp_in);
    @(posedge clk);
    if (take) begin
      m_val = nv;
      m_dpr = nd;
    end
    if (m_pre == 3) m_idx = (m_idx + 1) % 4;
    m_pre = (m_pre + 1) % 4;
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ld     = 1'b0;
    bcd_in = 16'h0;
    dp_in  = 4'h0;
    blank  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (seg !== 8'hFF || an !== 4'hF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: seg=%h an=%h err=%b required seg=ff an=f err=0", seg, an, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (an !== 4'hE || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL reset_first_edge: seg=%h an=%h required seg=c0 an=e", seg, an);
    end
    n_checks++;
    if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
      n_fail++;
      $display("FAIL reset_model: seg=%h an=%h err=%b required %h %h %b",
               seg, an, err, exp_seg, exp_an, exp_err);
    end
  endtask

  task automatic test_scan();
    bcd_in = 16'h1234;
    dp_in  = 4'b0100;
    ld     = 1'b1;
    tick();
    ld = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        n_fail++;
        $display("FAIL scan_1234[%0d]: seg=%h an=%h err=%b required %h %h %b",
                 c, seg, an, err, exp_seg, exp_an, exp_err);
      end
      if (an == 4'hB) begin
        n_checks++;
        if (seg !== 8'h24) begin
          n_fail++;
          $display("FAIL scan_dp_digit2: seg=%h required 24", seg);
        end
      end
    end
  endtask

  task automatic test_err();
    bcd_in = 16'h0A05;
    dp_in  = 4'b0000;
    ld     = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        n_fail++;
        $display("FAIL err_scan[%0d]: seg=%h an=%h err=%b required %h %h %b",
                 c, seg, an, err, exp_seg, exp_an, exp_err);
      end
      if (an == 4'hB) begin
        n_checks++;
        if (seg !== 8'h86) begin
          n_fail++;
          $display("FAIL err_glyph: seg=%h required 86", seg);
        end
      end
    end
    bcd_in = 16'h0905;
    ld     = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
  endtask

  task automatic test_blank();
    repeat (2) tick();
    blank = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (an !== 4'hF || seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL blank_dark[%0d]: seg=%h an=%h required ff f", c, seg, an);
      end
    end
    blank = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        n_fail++;
        $display("FAIL blank_resume[%0d]: seg=%h an=%h err=%b required %h %h %b",
                 c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
  endtask

  task automatic test_lzb();
    bcd_in = 16'h0007;
    dp_in  = 4'b0000;
    ld     = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      n_checks++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        n_fail++;
        $display("FAIL lzb_0007[%0d]: seg=%h an=%h err=%b required %h %h %b",
                 c, seg, an, err, exp_seg, exp_an, exp_err);
      end
      if (an == 4'hE) begin
        n_checks++;
        if (seg !== 8'hF8) begin
          n_fail++;
          $display("FAIL lzb_digit0: seg=%h required f8", seg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bcd_in = 16'h5678;
    ld     = 1'b1;
    tick();
    ld = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (an !== 4'hF || seg !== 8'hFF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: seg=%h an=%h err=%b required ff f 0", seg, an, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (an !== 4'hE || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL async_reset_val_cleared: seg=%h an=%h required c0 e", seg, an);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      ld     = ($urandom_range(0, 3) == 0);
      bcd_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bcd_in[15:8] = 8'h00;
      dp_in  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      blank  = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (seg !== exp_seg || an !== exp_an || err !== exp_err) begin
        n_fail++;
        $display("FAIL random[%0d]: seg=%h an=%h err=%b required %h %h %b",
                 c, seg, an, err, exp_seg, exp_an, exp_err);
      end
    end
    ld    = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    glyphs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};
    test_reset();
    test_scan();
    test_err();
    test_blank();
    test_lzb();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
